dma_axi_rd_master: RTL and testbench

- AXI4 read-side master front end. Sits directly downstream of the read streamer (STREAM_TYPE=0).
- Accepts one burst request per valid/ready handshake and issues it on the AR channel.
- Tracks outstanding bursts, checks beat counts against RLAST, and forwards R data with per-beat strobes to the DMA data buffer.
- Reports slave and protocol errors to the DMA FSM.

---
 rtl/dma_axi_rd_master.sv | 191 +++++++++++++++++++
 tb/tb_dma_axi_rd_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_axi_rd_master.sv
// AXI4 read-side master front end: issues AR bursts from streamer requests, tracks
// outstanding bursts, forwards R beats with per-beat strobes and reports errors.
module dma_axi_rd_master #(
   parameter int         ADDR_WIDTH      = 32,
   parameter int         DATA_WIDTH      = 512,
   parameter int         MAX_OUTSTANDING = 4,
   parameter logic [3:0] ID_VALUE        = 4'd0
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 req_valid_i,
   input  logic [ADDR_WIDTH-1:0]                req_addr_i,
   input  logic [7:0]                           req_alen_i,
   input  logic [2:0]                           req_size_i,
   input  logic [DATA_WIDTH/8-1:0]              req_strb_i,
   output logic                                 req_ready_o,
   output logic [3:0]                           m_arid_o,
   output logic [ADDR_WIDTH-1:0]                m_araddr_o,
   output logic [7:0]                           m_arlen_o,
   output logic [2:0]                           m_arsize_o,
   output logic [1:0]                           m_arburst_o,
   output logic                                 m_arvalid_o,
   input  logic                                 m_arready_i,
   input  logic [DATA_WIDTH-1:0]                m_rdata_i,
   input  logic [1:0]                           m_rresp_i,
   input  logic                                 m_rlast_i,
   input  logic                                 m_rvalid_i,
   output logic                                 m_rready_o,
   output logic [DATA_WIDTH-1:0]                rd_data_o,
   output logic [DATA_WIDTH/8-1:0]              rd_strb_o,
   output logic                                 rd_last_o,
   output logic                                 rd_valid_o,
   input  logic                                 rd_ready_i,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
   output logic                                 idle_o,
   output logic                                 err_valid_o,
   output logic [1:0]                           err_code_o,
   input  logic                                 err_clr_i
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   typedef struct packed {
      logic [7:0]    alen;
      logic [SW-1:0] strb;
   } trk_t;

   trk_t                  fifo_r [MAX_OUTSTANDING];
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         cnt_r;
   logic [7:0]            beat_cnt_r;
   logic                  err_valid_r;
   logic [1:0]            err_code_r;
   logic                  arvalid_r;
   logic [ADDR_WIDTH-1:0] araddr_r;
   logic [7:0]            arlen_r;
   logic [2:0]            arsize_r;

   logic                  has_out_s;
   logic                  accept_s;
   logic                  beat_s;
   logic                  pop_s;
   trk_t                  head_s;
   logic                  err_set_s;
   logic [1:0]            err_new_s;

   assign has_out_s   = (cnt_r != {CW{1'b0}});
   assign req_ready_o = (~arvalid_r | m_arready_i) & (cnt_r < MAX_CNT) & ~err_valid_r;
   assign accept_s    = req_valid_i & req_ready_o;
   assign m_rready_o  = rd_ready_i & has_out_s;
   assign beat_s      = m_rvalid_i & m_rready_o;
   assign pop_s       = beat_s & m_rlast_i;
   assign head_s      = fifo_r[rd_ptr_r];

   assign m_arid_o      = ID_VALUE;
   assign m_arburst_o   = 2'b01;
   assign m_arvalid_o   = arvalid_r;
   assign m_araddr_o    = araddr_r;
   assign m_arlen_o     = arlen_r;
   assign m_arsize_o    = arsize_r;
   assign rd_data_o     = m_rdata_i;
   assign rd_valid_o    = m_rvalid_i & has_out_s;
   assign rd_last_o     = m_rlast_i;
   assign outstanding_o = cnt_r;
   assign idle_o        = ~arvalid_r & ~has_out_s & ~req_valid_i;
   assign err_valid_o   = err_valid_r;
   assign err_code_o    = err_code_r;

   // Strobe only narrows single-beat bursts; zeroed while nothing is in flight
   always_comb begin
      rd_strb_o = {SW{1'b0}};
      if (!has_out_s) begin
         rd_strb_o = {SW{1'b0}};
      end else if (head_s.alen == 8'd0) begin
         rd_strb_o = head_s.strb;
      end else begin
         rd_strb_o = {SW{1'b1}};
      end
   end

   // Error detection: stray beat, bad response, or beat count disagreeing with RLAST
   always_comb begin
      err_set_s = 1'b0;
      err_new_s = 2'b00;
      if (m_rvalid_i && !has_out_s) begin
         err_set_s = 1'b1;
         err_new_s = 2'b11;
      end else if (beat_s && m_rresp_i[1]) begin
         err_set_s = 1'b1;
         err_new_s = m_rresp_i[0] ? 2'b10 : 2'b01;
      end else if (beat_s && (m_rlast_i != (beat_cnt_r == head_s.alen))) begin
         err_set_s = 1'b1;
         err_new_s = 2'b11;
      end else begin
         err_set_s = 1'b0;
         err_new_s = 2'b00;
      end
   end

   // AR channel registers: hold payload until handshake
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         arvalid_r <= 1'b0;
         araddr_r  <= {ADDR_WIDTH{1'b0}};
         arlen_r   <= 8'd0;
         arsize_r  <= 3'd0;
      end else if (accept_s) begin
         arvalid_r <= 1'b1;
         araddr_r  <= req_addr_i;
         arlen_r   <= req_alen_i;
         arsize_r  <= req_size_i;
      end else if (m_arready_i) begin
         arvalid_r <= 1'b0;
      end
   end

   // Tracking FIFO and outstanding counter; the accept gate prevents overflow
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_r[i] <= '0;
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         cnt_r    <= {CW{1'b0}};
      end else begin
         if (accept_s) begin
            fifo_r[wr_ptr_r] <= {req_alen_i, req_strb_i};
            wr_ptr_r         <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({accept_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CW'(1);
            2'b01:   cnt_r <= cnt_r - CW'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Beat counter of the head burst
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt_r <= 8'd0;
      end else if (pop_s) begin
         beat_cnt_r <= 8'd0;
      end else if (beat_s) begin
         beat_cnt_r <= beat_cnt_r + 8'd1;
      end
   end

   // Sticky error: first error wins, a new error beats a same-cycle clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_valid_r <= 1'b0;
         err_code_r  <= 2'b00;
      end else if (err_set_s && (!err_valid_r || err_clr_i)) begin
         err_valid_r <= 1'b1;
         err_code_r  <= err_new_s;
      end else if (err_clr_i) begin
         err_valid_r <= 1'b0;
         err_code_r  <= 2'b00;
      end
   end

endmodule

// File: tb/tb_dma_axi_rd_master.sv
// Directed bench for dma_axi_rd_master with a queue-based burst model checked every cycle.
module tb_dma_axi_rd_master;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req_valid_i;
   logic [31:0]   req_addr_i;
   logic [7:0]    req_alen_i;
   logic [2:0]    req_size_i;
   logic [63:0]   req_strb_i;
   logic          req_ready_o;
   logic [3:0]    m_arid_o;
   logic [31:0]   m_araddr_o;
   logic [7:0]    m_arlen_o;
   logic [2:0]    m_arsize_o;
   logic [1:0]    m_arburst_o;
   logic          m_arvalid_o;
   logic          m_arready_i;
   logic [511:0]  m_rdata_i;
   logic [1:0]    m_rresp_i;
   logic          m_rlast_i;
   logic          m_rvalid_i;
   logic          m_rready_o;
   logic [511:0]  rd_data_o;
   logic [63:0]   rd_strb_o;
   logic          rd_last_o;
   logic          rd_valid_o;
   logic          rd_ready_i;
   logic [2:0]    outstanding_o;
   logic          idle_o;
   logic          err_valid_o;
   logic [1:0]    err_code_o;
   logic          err_clr_i;

   dma_axi_rd_master dut (
      .clk(clk), .rstn(rstn),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_alen_i(req_alen_i),
      .req_size_i(req_size_i), .req_strb_i(req_strb_i), .req_ready_o(req_ready_o),
      .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
      .m_arsize_o(m_arsize_o), .m_arburst_o(m_arburst_o), .m_arvalid_o(m_arvalid_o),
      .m_arready_i(m_arready_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
      .m_rlast_i(m_rlast_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
      .rd_data_o(rd_data_o), .rd_strb_o(rd_strb_o), .rd_last_o(rd_last_o),
      .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .outstanding_o(outstanding_o),
      .idle_o(idle_o), .err_valid_o(err_valid_o), .err_code_o(err_code_o),
      .err_clr_i(err_clr_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  alen;
      logic [63:0] strb;
   } burst_t;

   burst_t      bq[$];
   logic        ar_pend;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   int          beats;
   logic        err_v;
   logic [1:0]  err_c;
   int          checks = 0;
   int          passes = 0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic set_idle();
      req_valid_i = 1'b0; req_addr_i = 32'd0; req_alen_i = 8'd0; req_size_i = 3'd0;
      req_strb_i = 64'd0; m_arready_i = 1'b1; m_rdata_i = 512'd0; m_rresp_i = 2'b00;
      m_rlast_i = 1'b0; m_rvalid_i = 1'b0; rd_ready_i = 1'b1; err_clr_i = 1'b0;
   endtask

   // Compare every output against the model, then advance the model across one edge
   task automatic step();
      logic       e_ready, acc, e_rready, beat, n_set, n_pend;
      logic [1:0] n_code;
      logic [63:0] e_strb;
      int          n = bq.size();
      #2;
      e_ready  = (!ar_pend || m_arready_i) && (n < 4) && !err_v;
      acc      = req_valid_i && e_ready;
      e_rready = rd_ready_i && (n != 0);
      beat     = m_rvalid_i && e_rready;
      e_strb   = (n == 0) ? 64'd0 : ((bq[0].alen == 8'd0) ? bq[0].strb : {64{1'b1}});
      chk("req_ready", req_ready_o, e_ready);
      chk("arvalid", m_arvalid_o, ar_pend);
      if (ar_pend) begin
         chk("araddr", m_araddr_o, ar_addr);
         chk("arlen", m_arlen_o, ar_len);
         chk("arsize", m_arsize_o, ar_size);
      end
      chk("arburst", m_arburst_o, 2'b01);
      chk("arid", m_arid_o, 4'd0);
      chk("rready", m_rready_o, e_rready);
      chk("rd_valid", rd_valid_o, m_rvalid_i && (n != 0));
      if (m_rvalid_i && (n != 0)) begin
         chk("rd_data", rd_data_o, m_rdata_i);
         chk("rd_strb", rd_strb_o, e_strb);
         chk("rd_last", rd_last_o, m_rlast_i);
      end
      chk("outstanding", outstanding_o, n);
      chk("idle", idle_o, !ar_pend && (n == 0) && !req_valid_i);
      chk("err_valid", err_valid_o, err_v);
      chk("err_code", err_code_o, err_c);
      n_set = 1'b0; n_code = 2'b00;
      if (m_rvalid_i && n == 0) begin
         n_set = 1'b1; n_code = 2'b11;
      end else if (beat && m_rresp_i >= 2'd2) begin
         n_set = 1'b1; n_code = (m_rresp_i == 2'd2) ? 2'b01 : 2'b10;
      end else if (beat && (m_rlast_i != (beats == int'(bq[0].alen)))) begin
         n_set = 1'b1; n_code = 2'b11;
      end
      n_pend = acc ? 1'b1 : (m_arready_i ? 1'b0 : ar_pend);
      @(posedge clk); #1;
      if (acc) begin
         ar_addr = req_addr_i; ar_len = req_alen_i; ar_size = req_size_i;
      end
      ar_pend = n_pend;
      if (beat && m_rlast_i) begin
         void'(bq.pop_front());
         beats = 0;
      end else if (beat) begin
         beats++;
      end
      if (acc) bq.push_back('{req_alen_i, req_strb_i});
      if (n_set && (!err_v || err_clr_i)) begin
         err_v = 1'b1; err_c = n_code;
      end else if (err_clr_i) begin
         err_v = 1'b0; err_c = 2'b00;
      end
   endtask

   task automatic req(input logic [31:0] a, input logic [7:0] l, input logic [63:0] s);
      req_valid_i = 1'b1; req_addr_i = a; req_alen_i = l; req_size_i = 3'd6; req_strb_i = s;
   endtask

   task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] resp);
      m_rvalid_i = 1'b1; m_rdata_i = {16{d}}; m_rlast_i = last; m_rresp_i = resp;
      step();
      m_rvalid_i = 1'b0; m_rlast_i = 1'b0; m_rresp_i = 2'b00;
   endtask

   initial begin
      set_idle();
      rstn = 1'b0;
      bq.delete(); ar_pend = 1'b0; ar_addr = 32'd0; ar_len = 8'd0; ar_size = 3'd0;
      beats = 0; err_v = 1'b0; err_c = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_idle", idle_o, 1'b1);
      chk("rst_outstanding", outstanding_o, 3'd0);
      chk("rst_arvalid", m_arvalid_o, 1'b0);
      chk("rst_arburst", m_arburst_o, 2'b01);
      chk("rst_err_valid", err_valid_o, 1'b0);
      rstn = 1'b1;
      step();

      // 4-beat burst
      req(32'h1000, 8'd3, 64'd0);
      step();
      req_valid_i = 1'b0;
      #1;
      chk("s1_araddr", m_araddr_o, 32'h1000);
      chk("s1_outstanding", outstanding_o, 3'd1);
      step(); step();
      for (int i = 0; i < 4; i++) beat(32'hA000 + i, i == 3, 2'b00);
      #1;
      chk("s1_idle", idle_o, 1'b1);
      step();

      // narrow single-beat burst
      req(32'h2010, 8'd0, 64'h0000_FFFF_0000);
      step();
      req_valid_i = 1'b0;
      step();
      m_rvalid_i = 1'b1; m_rlast_i = 1'b1; m_rdata_i = {16{32'hBEEF}};
      #1;
      chk("s2_strb", rd_strb_o, 64'h0000_FFFF_0000);
      chk("s2_last", rd_last_o, 1'b1);
      step();
      m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
      step();

      // five back-to-back requests with R stalled
      for (int k = 0; k < 5; k++) begin
         req(32'h3000 + 32'(k) * 32'h40, 8'd0, 64'hFF);
         if (k == 4) begin
            #1;
            chk("s3_full_block", req_ready_o, 1'b0);
         end
         step();
      end
      step();
      beat(32'hC0, 1'b1, 2'b00);
      step();
      req_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) beat(32'hC1 + k, 1'b1, 2'b00);
      step();

      // AR stall for three cycles
      m_arready_i = 1'b0;
      req(32'h4000, 8'd1, 64'd0);
      step();
      req(32'h4040, 8'd1, 64'd0);
      #1;
      chk("s4_ready_low", req_ready_o, 1'b0);
      repeat (3) step();
      chk("s4_araddr_hold", m_araddr_o, 32'h4000);
      m_arready_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      step();
      beat(32'hD0, 1'b0, 2'b00); beat(32'hD1, 1'b1, 2'b00);
      beat(32'hD2, 1'b0, 2'b00); beat(32'hD3, 1'b1, 2'b00);

      // SLVERR on beat 2
      req(32'h5000, 8'd3, 64'd0);
      step();
      req_valid_i = 1'b0;
      step();
      beat(32'hE0, 1'b0, 2'b00);
      beat(32'hE1, 1'b0, 2'b10);
      #1;
      chk("s5_err_valid", err_valid_o, 1'b1);
      chk("s5_err_code", err_code_o, 2'b01);
      req(32'h5100, 8'd0, 64'd1);
      #1;
      chk("s5_blocked", req_ready_o, 1'b0);
      beat(32'hE2, 1'b0, 2'b00);
      beat(32'hE3, 1'b1, 2'b00);
      req_valid_i = 1'b0;
      step();
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      #1;
      chk("s5_cleared", err_valid_o, 1'b0);
      step();

      // early RLAST on the third beat
      req(32'h6000, 8'd3, 64'd0);
      step();
      req_valid_i = 1'b0;
      step();
      beat(32'hF0, 1'b0, 2'b00); beat(32'hF1, 1'b0, 2'b00); beat(32'hF2, 1'b1, 2'b00);
      #1;
      chk("s6_err_code", err_code_o, 2'b11);
      chk("s6_retired", outstanding_o, 3'd0);
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      step();

      // stray beat with nothing outstanding, then clear racing a new error
      beat(32'h77, 1'b1, 2'b00);
      err_clr_i = 1'b1;
      beat(32'h78, 1'b1, 2'b00);
      #1;
      chk("s7_new_wins", err_valid_o, 1'b1);
      step();
      err_clr_i = 1'b0;
      #1;
      chk("s7_cleared", err_valid_o, 1'b0);
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
